trigger_capture_sequencer: RTL and testbench
============================================

// Module: trigger_capture_sequencer
// PURPOSE
//  Sequences an N-bit serial-to-parallel shift capture, started by a rising edge on a level trigger.
//  Integrates the level-to-pulse edge detector with a bit counter, shift register and output holding register.
//  Presents each captured word on a valid/ready handshake and flags triggers lost while the block is busy.
//  Sits between the level-trigger front end and the downstream word consumer.
// PARAMETERS
//  N          8   capture word width in bits; legal range N >= 2
//  MSB_FIRST  1   1: serial_in enters at bit 0, shifts left (first bit ends in MSB); 0: enters at bit N-1, shifts right
// PORTS
//  clk          in   1              clock; all state updates on rising edge
//  reset        in   1              asynchronous, active-low reset
//  trigger      in   1              level trigger; a 0->1 transition starts a capture
//  serial_in    in   1              serial data bit, sampled when bit_en=1 in SHIFT
//  bit_en       in   1              bit-slot strobe; one bit captured per posedge with bit_en=1
//  abort        in   1              synchronous abort of capture/hold
//  data_ready   in   1              consumer ready
//  clr_ovr      in   1              synchronous clear of overrun
//  edge_pulse   out  1              one-cycle pulse for every detected trigger rise (any state)
//  busy         out  1              high in SHIFT and HOLD
//  data_valid   out  1              captured word available on data_out
//  data_out     out  N              captured word, stable while data_valid=1
//  bit_count    out  $clog2(N)      bits captured so far in current word
//  overrun      out  1              sticky: trigger rise occurred while busy
// BEHAVIOUR
//  Reset (reset=0, async):
//  - state=IDLE; trig_q=1 (a trigger held high through reset does not start a capture).
//  - All outputs 0; shift register cleared.
//  Edge detect:
//  - rise = trigger & ~trig_q, evaluated at each posedge; trig_q <= trigger every cycle.
//  - edge_pulse <= rise: high exactly the one cycle after the posedge that sees the rise.
//  - Trigger held high gives a single pulse.
//  FSM IDLE/SHIFT/HOLD:
//  - IDLE: rise -> SHIFT, bit_count<=0, shift reg cleared. busy=1 from the next cycle.
//  - SHIFT: each posedge with bit_en=1 shifts serial_in in, bit_count++.
//      bit_en=0 holds all state.
//  - SHIFT: on the posedge with bit_en=1 and bit_count==N-1, the final bit is included.
//      That edge loads data_out, sets data_valid=1, bit_count<=0 -> HOLD.
//  - HOLD: data_out/data_valid held. Posedge with data_valid & data_ready -> IDLE, data_valid<=0.
//      Minimum rise-to-valid latency: N cycles when bit_en is constant 1 from the cycle after the rise.
//  - abort=1 in SHIFT or HOLD -> IDLE next edge: partial word discarded, data_valid<=0, bit_count<=0.
//      abort beats a completing bit and a same-cycle handshake. abort in IDLE: no effect;
//      a same-cycle rise in IDLE still starts a capture.
//  - rise in SHIFT/HOLD: ignored for sequencing; overrun<=1. Still produces edge_pulse.
//  - rise in the same cycle as the HOLD handshake: block goes IDLE, capture NOT started, overrun set.
//  - overrun cleared by clr_ovr=1. Same-cycle set and clear: set wins.
//  - data_out retains the last word after the handshake; consumers qualify it with data_valid.
// TESTING
//  1 Reset with trigger=1, release -> no edge_pulse, busy=0, all outputs 0;
//    then asserting reset mid-SHIFT -> immediate IDLE, outputs 0.
//  2 N=8, MSB_FIRST=1, bit_en=1, data_ready=1; rise, then serial 1,0,1,1,0,0,1,0 ->
//    edge_pulse for 1 cycle, data_valid high for 1 cycle with data_out=8'hB2 exactly 8 cycles after the rise.
//  3 Same stream with MSB_FIRST=0 -> data_out=8'h4D.
//    Same stream with bit_en toggling 1/0 -> word unchanged, valid after 16 cycles.
//  4 data_ready=0 for 5 cycles after valid -> data_out/data_valid stable.
//    Second trigger rise during HOLD -> overrun=1, no new capture.
//    clr_ovr together with a new rise -> overrun stays 1.
//  5 abort after 3 bits -> IDLE next cycle, bit_count=0, no data_valid.
//    Fresh capture afterwards is correct (no leftover bits).
//  6 Trigger pattern 0,0,1,1,1,0,1,1,0 from IDLE with N=2 -> edge_pulse exactly one cycle after each 0->1.
//    The second rise lands in SHIFT -> overrun set, first word still delivered.

Source files
------------

// File: rtl/trigger_capture_sequencer.sv
// ----------------------------------------------------------------------------
// trigger_capture_sequencer
//
// Serial-to-parallel word capture started by a rising edge on a level
// trigger. The trigger is converted to a one-cycle pulse, an N-bit word is
// shifted in on bit_en strobes, and the completed word is held on a
// valid/ready handshake. Trigger rises that arrive while the block is busy
// are flagged on a sticky overrun bit.
//
// Ports
//   clk         clock, all state changes on the rising edge
//   reset       asynchronous, active-low reset
//   trigger     level trigger; a 0->1 transition starts a capture
//   serial_in   serial data bit, sampled on bit_en while shifting
//   bit_en      bit-slot strobe, one bit per enabled edge
//   abort       synchronous abort of a capture or a held word
//   data_ready  consumer ready
//   clr_ovr     synchronous clear of overrun
//   edge_pulse  one-cycle pulse per detected trigger rise
//   busy        high while shifting or holding a word
//   data_valid  captured word available on data_out
//   data_out    captured word
//   bit_count   bits captured so far in the current word
//   overrun     sticky flag: trigger rose while busy
//
// State table
//   state    | meaning
//   IDLE     | waiting for a trigger rise
//   SHIFT    | collecting bits on bit_en strobes
//   HOLD     | word presented, waiting for data_ready
// ----------------------------------------------------------------------------
module trigger_capture_sequencer #(
    parameter int N         = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 trigger,
    input  logic                 serial_in,
    input  logic                 bit_en,
    input  logic                 abort,
    input  logic                 data_ready,
    input  logic                 clr_ovr,
    output logic                 edge_pulse,
    output logic                 busy,
    output logic                 data_valid,
    output logic [N-1:0]         data_out,
    output logic [$clog2(N)-1:0] bit_count,
    output logic                 overrun
);

    localparam int CW = $clog2(N);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic [1:0]   state;
    logic         trig_q;
    logic [N-1:0] shift_reg;
    logic [N-1:0] shift_next;
    logic         rise;
    logic         last_bit;

    assign rise     = trigger & ~trig_q;
    assign last_bit = (bit_count == CW'(N - 1));
    assign busy     = (state != ST_IDLE);

    // MSB-first: new bits enter at bit 0 so the first bit ends in the MSB.
    // LSB-first: new bits enter at the top so the first bit ends in bit 0.
    always_comb begin
        shift_next = '0;
        if (MSB_FIRST)
            shift_next = {shift_reg[N-2:0], serial_in};
        else
            shift_next = {serial_in, shift_reg[N-1:1]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            // Starting high means a trigger held through reset is not a rise.
            trig_q     <= 1'b1;
            edge_pulse <= 1'b0;
            overrun    <= 1'b0;
            shift_reg  <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            bit_count  <= '0;
        end else begin
            trig_q     <= trigger;
            edge_pulse <= rise;

            // Set takes priority over a same-cycle clear.
            if (rise && busy)
                overrun <= 1'b1;
            else if (clr_ovr)
                overrun <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (rise) begin
                        state     <= ST_SHIFT;
                        bit_count <= '0;
                        shift_reg <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (abort) begin
                        state     <= ST_IDLE;
                        bit_count <= '0;
                        shift_reg <= '0;
                    end else if (bit_en) begin
                        shift_reg <= shift_next;
                        if (last_bit) begin
                            data_out   <= shift_next;
                            data_valid <= 1'b1;
                            bit_count  <= '0;
                            state      <= ST_HOLD;
                        end else begin
                            bit_count <= bit_count + 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    // A rise coinciding with the handshake only sets overrun;
                    // the block returns to IDLE without starting a capture.
                    if (abort) begin
                        state      <= ST_IDLE;
                        data_valid <= 1'b0;
                        bit_count  <= '0;
                        shift_reg  <= '0;
                    end else if (data_valid && data_ready) begin
                        state      <= ST_IDLE;
                        data_valid <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    data_valid <= 1'b0;
                    bit_count  <= '0;
                    shift_reg  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trigger_capture_sequencer.sv
module tb_trigger_capture_sequencer;

    logic clk = 1'b0;
    logic reset, trigger, serial_in, bit_en, abort, data_ready, clr_ovr;

    logic       m_pulse, m_busy, m_valid, m_ovr;
    logic [7:0] m_data;
    logic [2:0] m_cnt;
    logic       l_pulse, l_busy, l_valid, l_ovr;
    logic [7:0] l_data;
    logic [2:0] l_cnt;
    logic       s_pulse, s_busy, s_valid, s_ovr;
    logic [1:0] s_data;
    logic [0:0] s_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    trigger_capture_sequencer #(.N(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset(reset), .trigger(trigger), .serial_in(serial_in),
        .bit_en(bit_en), .abort(abort), .data_ready(data_ready), .clr_ovr(clr_ovr),
        .edge_pulse(m_pulse), .busy(m_busy), .data_valid(m_valid),
        .data_out(m_data), .bit_count(m_cnt), .overrun(m_ovr));

    trigger_capture_sequencer #(.N(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .trigger(trigger), .serial_in(serial_in),
        .bit_en(bit_en), .abort(abort), .data_ready(data_ready), .clr_ovr(clr_ovr),
        .edge_pulse(l_pulse), .busy(l_busy), .data_valid(l_valid),
        .data_out(l_data), .bit_count(l_cnt), .overrun(l_ovr));

    trigger_capture_sequencer #(.N(2), .MSB_FIRST(1'b1)) u_n2 (
        .clk(clk), .reset(reset), .trigger(trigger), .serial_in(serial_in),
        .bit_en(bit_en), .abort(abort), .data_ready(data_ready), .clr_ovr(clr_ovr),
        .edge_pulse(s_pulse), .busy(s_busy), .data_valid(s_valid),
        .data_out(s_data), .bit_count(s_cnt), .overrun(s_ovr));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_m_pulse"}, 32'(m_pulse), 0);
        chk({tag, "_m_busy"},  32'(m_busy),  0);
        chk({tag, "_m_valid"}, 32'(m_valid), 0);
        chk({tag, "_m_data"},  32'(m_data),  0);
        chk({tag, "_m_cnt"},   32'(m_cnt),   0);
        chk({tag, "_m_ovr"},   32'(m_ovr),   0);
        chk({tag, "_l_pulse"}, 32'(l_pulse), 0);
        chk({tag, "_l_busy"},  32'(l_busy),  0);
        chk({tag, "_l_valid"}, 32'(l_valid), 0);
        chk({tag, "_l_data"},  32'(l_data),  0);
        chk({tag, "_l_cnt"},   32'(l_cnt),   0);
        chk({tag, "_l_ovr"},   32'(l_ovr),   0);
        chk({tag, "_s_pulse"}, 32'(s_pulse), 0);
        chk({tag, "_s_busy"},  32'(s_busy),  0);
        chk({tag, "_s_valid"}, 32'(s_valid), 0);
        chk({tag, "_s_data"},  32'(s_data),  0);
        chk({tag, "_s_cnt"},   32'(s_cnt),   0);
        chk({tag, "_s_ovr"},   32'(s_ovr),   0);
    endtask

    // Full 8-bit capture with bit_en held high from the cycle after the rise.
    task automatic run_capture(input logic [7:0] w, input logic [7:0] exp_msb,
                               input logic [7:0] exp_lsb);
        trigger = 1'b0; bit_en = 1'b0; data_ready = 1'b1;
        tick();
        trigger = 1'b1;
        tick();
        chk("cap_pulse", 32'(m_pulse), 1);
        chk("cap_busy",  32'(m_busy),  1);
        bit_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            serial_in = w[7-i];
            tick();
            if (i == 1) chk("cap_pulse_single", 32'(m_pulse), 0);
            if (i < 7)  chk("cap_early_valid", 32'(m_valid), 0);
        end
        chk("cap_valid_msb", 32'(m_valid), 1);
        chk("cap_data_msb",  32'(m_data),  32'(exp_msb));
        chk("cap_valid_lsb", 32'(l_valid), 1);
        chk("cap_data_lsb",  32'(l_data),  32'(exp_lsb));
        bit_en = 1'b0; serial_in = 1'b0;
        tick();
        chk("cap_valid_drop", 32'(m_valid), 0);
        chk("cap_idle",       32'(m_busy),  0);
        chk("cap_data_kept",  32'(m_data),  32'(exp_msb));
    endtask

    logic [7:0] w_b2;
    logic [8:0] t6_trig, t6_ben, t6_sin, t6_pulse, t6_ovr, t6_valid;

    initial begin
        w_b2 = 8'hB2;
        reset = 1'b1; trigger = 1'b1; serial_in = 1'b0; bit_en = 1'b0;
        abort = 1'b0; data_ready = 1'b0; clr_ovr = 1'b0;

        // 1: reset with trigger high, then release
        #3 reset = 1'b0;
        tick(); tick();
        check_all_zero("rst");
        reset = 1'b1;
        tick(); tick();
        check_all_zero("rst_rel");

        // 1b: asynchronous reset in the middle of SHIFT
        trigger = 1'b0;
        tick();
        trigger = 1'b1; bit_en = 1'b1; serial_in = 1'b1;
        tick();
        chk("mid_pulse", 32'(m_pulse), 1);
        chk("mid_busy",  32'(m_busy),  1);
        tick();
        chk("mid_cnt", 32'(m_cnt), 1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(m_busy), 0);
        chk("mid_rst_cnt",  32'(m_cnt),  0);
        reset = 1'b1; trigger = 1'b0; bit_en = 1'b0; serial_in = 1'b0;

        // 2 / 3a: B2 stream, both bit orders
        run_capture(8'hB2, 8'hB2, 8'h4D);

        // 3b: bit_en toggling, then 4: stalled consumer
        trigger = 1'b0; bit_en = 1'b0; data_ready = 1'b0;
        tick();
        trigger = 1'b1;
        tick();
        for (int c = 1; c <= 16; c++) begin
            bit_en    = (c % 2 == 0);
            serial_in = (c % 2 == 0) ? w_b2[8 - c/2] : 1'b0;
            tick();
            if (c < 16) chk("tog_early_valid", 32'(m_valid), 0);
        end
        chk("tog_valid",    32'(m_valid), 1);
        chk("tog_data_msb", 32'(m_data),  32'hB2);
        chk("tog_data_lsb", 32'(l_data),  32'h4D);
        bit_en = 1'b0; serial_in = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            trigger = (k == 2) ? 1'b0 : 1'b1;
            tick();
            chk("hold_valid", 32'(m_valid), 1);
            chk("hold_data",  32'(m_data),  32'hB2);
            chk("hold_ovr",   32'(m_ovr),   (k >= 3) ? 32'd1 : 32'd0);
        end
        chk("hold_busy", 32'(m_busy), 1);
        trigger = 1'b0;
        tick();
        clr_ovr = 1'b1;
        tick();
        chk("ovr_clear", 32'(m_ovr), 0);
        clr_ovr = 1'b0;
        trigger = 1'b1; data_ready = 1'b1;
        tick();
        chk("hs_rise_busy",  32'(m_busy),  0);
        chk("hs_rise_valid", 32'(m_valid), 0);
        chk("hs_rise_ovr",   32'(m_ovr),   1);
        chk("hs_rise_pulse", 32'(m_pulse), 1);
        tick();
        chk("hs_rise_nostart", 32'(m_busy), 0);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        chk("ovr_clear2", 32'(m_ovr), 0);
        trigger = 1'b0;
        tick();
        trigger = 1'b1;
        tick();
        chk("ovr_start_busy", 32'(m_busy), 1);
        chk("ovr_start_ovr",  32'(m_ovr),  0);
        trigger = 1'b0;
        tick();
        trigger = 1'b1; clr_ovr = 1'b1;
        tick();
        chk("ovr_set_wins", 32'(m_ovr), 1);
        tick();
        chk("ovr_clr_after", 32'(m_ovr), 0);
        clr_ovr = 1'b0; abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_shift_idle", 32'(m_busy), 0);

        // 5: abort after three bits, then a clean capture
        trigger = 1'b0;
        tick();
        trigger = 1'b1; data_ready = 1'b1;
        tick();
        bit_en = 1'b1; serial_in = 1'b1;
        tick(); tick(); tick();
        chk("ab_cnt3", 32'(m_cnt), 3);
        abort = 1'b1;
        tick();
        abort = 1'b0; bit_en = 1'b0; serial_in = 1'b0;
        chk("ab_busy",  32'(m_busy),  0);
        chk("ab_cnt",   32'(m_cnt),   0);
        chk("ab_valid", 32'(m_valid), 0);
        tick();
        chk("ab_valid2", 32'(m_valid), 0);
        run_capture(8'h0F, 8'h0F, 8'hF0);

        // 6: N=2 trigger pattern, second rise lands in SHIFT
        trigger = 1'b0; abort = 1'b1;
        tick();
        abort = 1'b0; clr_ovr = 1'b1; data_ready = 1'b0;
        tick();
        clr_ovr = 1'b0;
        chk("t6_pre_busy", 32'(s_busy), 0);
        chk("t6_pre_ovr",  32'(s_ovr),  0);
        t6_trig  = 9'b011011100;
        t6_ben   = 9'b010001000;
        t6_sin   = 9'b000001000;
        t6_pulse = 9'b001000100;
        t6_ovr   = 9'b111000000;
        t6_valid = 9'b110000000;
        for (int e = 0; e < 9; e++) begin
            trigger   = t6_trig[e];
            bit_en    = t6_ben[e];
            serial_in = t6_sin[e];
            tick();
            chk("t6_pulse", 32'(s_pulse), 32'(t6_pulse[e]));
            chk("t6_ovr",   32'(s_ovr),   32'(t6_ovr[e]));
            chk("t6_valid", 32'(s_valid), 32'(t6_valid[e]));
        end
        chk("t6_data", 32'(s_data), 32'h2);
        bit_en = 1'b0; serial_in = 1'b0; data_ready = 1'b1;
        tick();
        chk("t6_hs_valid", 32'(s_valid), 0);
        chk("t6_hs_busy",  32'(s_busy),  0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
